// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter that lets two producers share the single packed
// write port of the FIFO controller. Each push carries two DATA_WIDTH slots,
// so a push is only allowed while the FIFO has at least two free slots.
// A grant tenure ends after MAX_BURST accepted pushes, or as soon as the owner
// drops valid, so neither producer can starve the other.
//
// Optional feature macro: FIFO_WR_ARB_STATS_EN
//   When defined, the block adds per-requester accept counters and a stall
//   counter (all 16-bit, saturating) plus a synchronous clear input.
//
// Ports
//   clk            clock, all state on the rising edge
//   reset          asynchronous, active-high reset
//   req0_valid     producer 0 has a word
//   req0_data      producer 0 word (2*DATA_WIDTH)
//   req0_ready     producer 0 word taken this cycle when valid & ready
//   req1_valid     producer 1 has a word
//   req1_data      producer 1 word (2*DATA_WIDTH)
//   req1_ready     producer 1 word taken this cycle when valid & ready
//   fifo_full      FIFO controller is full
//   fifo_one_left  FIFO controller has exactly one free slot
//   fifo_wr        push strobe to the FIFO controller
//   fifo_wdata     pushed word; low half lands in the first slot
//   grant          one-hot current owner {G1, G0}; 2'b00 when idle
//   stats_clr      (stats only) synchronous clear of all counters
//   acc0_cnt       (stats only) accepted pushes from producer 0
//   acc1_cnt       (stats only) accepted pushes from producer 1
//   stall_cnt      (stats only) cycles with owner valid but no FIFO space
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  input  logic [2*DATA_WIDTH-1:0] req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [2*DATA_WIDTH-1:0] req1_data,
  output logic                    req1_ready,
  input  logic                    fifo_full,
  input  logic                    fifo_one_left,
  output logic                    fifo_wr,
  output logic [2*DATA_WIDTH-1:0] fifo_wdata,
  output logic [1:0]              grant
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [15:0]             acc0_cnt,
  output logic [15:0]             acc1_cnt,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt, cnt_inc;
  logic          last_served, last_nxt;

  logic          space;
  logic          in_g0, in_g1;
  logic          own_vld, oth_vld;
  logic          accept;
  logic          rel;

  // A push writes two slots, so one free slot is as good as none.
  assign space   = ~fifo_full & ~fifo_one_left;

  assign in_g0   = (state == G0);
  assign in_g1   = (state == G1);

  assign own_vld = (in_g0 & req0_valid) | (in_g1 & req1_valid);
  assign oth_vld = (in_g0 & req1_valid) | (in_g1 & req0_valid);

  assign accept  = own_vld & space;
  assign cnt_inc = burst_cnt + 1'b1;

  // Tenure ends on the last allowed push of the burst, or when the owner has
  // nothing to send. A space stall keeps the grant and the count.
  assign rel     = (in_g0 | in_g1) &
                   (~own_vld | (accept & (cnt_inc == BURST_MAX)));

  // Outputs are pure decodes of the registered state, so reset clears them
  // in the same cycle it is asserted.
  assign grant      = {in_g1, in_g0};
  assign req0_ready = in_g0 & space;
  assign req1_ready = in_g1 & space;
  assign fifo_wr    = accept;
  assign fifo_wdata = in_g0 ? req0_data :
                      in_g1 ? req1_data : '0;

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    last_nxt  = last_served;
    case (state)
      IDLE: begin
        // Grants from IDLE only take effect next cycle; nothing is pushed here.
        if (req0_valid & req1_valid)
          state_nxt = last_served ? G0 : G1;
        else if (req0_valid)
          state_nxt = G0;
        else if (req1_valid)
          state_nxt = G1;
      end
      G0, G1: begin
        if (rel) begin
          last_nxt  = in_g1;
          burst_nxt = '0;
          // Other side first; otherwise the owner starts a fresh tenure
          // without passing through IDLE, keeping the port busy.
          if (oth_vld)
            state_nxt = in_g0 ? G1 : G0;
          else if (own_vld)
            state_nxt = state;
          else
            state_nxt = IDLE;
        end else if (accept) begin
          burst_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= 1'b1;  // producer 0 wins the first contested grant
    end else begin
      state       <= state_nxt;
      burst_cnt   <= burst_nxt;
      last_served <= last_nxt;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic stall;
  assign stall = own_vld & ~space;

  // Saturating counters; clear has priority over any increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc0_cnt  <= '0;
      acc1_cnt  <= '0;
      stall_cnt <= '0;
    end else if (stats_clr) begin
      acc0_cnt  <= '0;
      acc1_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept & in_g0 & (acc0_cnt != 16'hFFFF))
        acc0_cnt <= acc0_cnt + 16'd1;
      if (accept & in_g1 & (acc1_cnt != 16'hFFFF))
        acc1_cnt <= acc1_cnt + 16'd1;
      if (stall & (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one packed-write port of the FIFO controller (two DATA_WIDTH slots per push) between two producers.
- Each producer uses a valid/ready handshake.
- Arbiter gates pushes on FIFO space (~fifo_full & ~fifo_one_left), so a push never lands with fewer than two free slots.
- Bounded bursts (MAX_BURST) keep either producer from starving the other.

Parameters:
DATA_WIDTH, 8, width of one FIFO slot; producer words are 2*DATA_WIDTH.
MAX_BURST, 4, maximum accepted pushes per grant tenure before re-arbitration (>=1).

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  producer 0 has a word
req0_data  input  2*DATA_WIDTH  producer 0 word
req0_ready  output  1  producer 0 word accepted this cycle when valid&ready
req1_valid  input  1  producer 1 has a word
req1_data  input  2*DATA_WIDTH  producer 1 word
req1_ready  output  1  producer 1 accept
fifo_full  input  1  from FIFO controller
fifo_one_left  input  1  from FIFO controller; exactly one free slot
fifo_wr  output  1  push strobe to FIFO controller
fifo_wdata  output  2*DATA_WIDTH  word pushed; low half = first slot
grant  output  2  one-hot current owner; 2'b00 when idle

Behaviour:
- space = ~fifo_full & ~fifo_one_left, combinational.
- FSM states: IDLE, G0, G1. Registered state, burst_cnt ($clog2(MAX_BURST+1) bits), last_served (1 bit).
- Reset values (async, immediate):
  - state=IDLE, burst_cnt=0, last_served=1 (req0 wins first).
  - Outputs: grant=00, req0_ready=0, req1_ready=0, fifo_wr=0, fifo_wdata=0.
- Outputs are decoded from state; they are not registered:
  - grant = {state==G1, state==G0}.
  - reqK_ready = (state==GK) & space.
  - fifo_wr = accept = owner valid & owner ready.
  - fifo_wdata = owner data when in GK, else 0.
- IDLE:
  - If both valid, grant the requester != last_served.
  - Else grant whichever is valid.
  - Else stay IDLE.
  - Grant takes effect next cycle. First accept is therefore >=1 cycle after valid rises; there are no pushes from IDLE.
- GK, each cycle:
  - On accept: burst_cnt+1.
  - Release when (accept & burst_cnt+1==MAX_BURST) or ~reqK_valid.
  - On release: last_served=K, burst_cnt=0. Next state:
    - G(other) if other valid.
    - Else GK if reqK_valid (fresh tenure).
    - Else IDLE.
  - No release otherwise; state and count hold, including while space=0 (stall does not forfeit grant).
- Steady-state throughput: one push per cycle while owner valid and space=1.
- Producer rule: once valid asserted, data/valid held until accepted. The arbiter never accepts from a non-granted producer.
- Simultaneous accept and release: the accepted word is pushed this cycle, then the switch occurs. There is no lost or duplicated word.
- space drops in the same cycle as valid: no push; ready=0.
- Reset mid-burst: grant and ready drop immediately. Any un-accepted word stays with its producer.

Optional Feature:
Macro FIFO_WR_ARB_STATS_EN.
- Defined: adds outputs acc0_cnt[15:0], acc1_cnt[15:0], stall_cnt[15:0].
  - accK_cnt: counts accepts per requester.
  - stall_cnt: counts cycles with owner valid & ~space.
  - All three saturate at 16'hFFFF, reset to 0 asynchronously.
  - Synchronous clear input stats_clr (1 bit) zeroes all three the next edge; clear wins over increment.
- Undefined: these ports and registers do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, req0_valid=1 only, space=1 -> grant=01 cycle 1, fifo_wr on cycles 1-4 with req0_data, release after 4th push; re-grant G0 with burst_cnt=0.
- Both valid continuously, MAX_BURST=4, space=1 -> pushes alternate in runs of 4 (0,0,0,0,1,1,1,1,...), one gap cycle only from IDLE at start.
- G0 holding, fifo_one_left=1 for 3 cycles -> req0_ready=0, fifo_wr=0, grant stays 01. Push resumes the cycle one_left clears; burst_cnt unchanged across stall.
- req1 drops valid after 2 accepts, req0 valid -> cycle of release grants G0 next; last_served=1; no push from req1 after drop.
- Assert reset mid-burst (burst_cnt=2, G1) -> same-cycle grant=00, req1_ready=0, fifo_wr=0. After release, req0 granted first.
- FIFO_WR_ARB_STATS_EN: 5 accepts req0, 3 req1, 2 stall cycles -> acc0_cnt=5, acc1_cnt=3, stall_cnt=2. stats_clr pulse -> all 0 next edge.
